proc_control_fsm: RTL

- Sequences the 16-bit processor datapath through fetch, decode and execute.
- Drives the PC, IR load, data memory, register file and ALU select, using the instruction held in the IR.
- Exposes its current state on `state_o` for the debug display (HEX4 in the PC/state view).
- Sits inside the processor, between the instruction register and the datapath control pins.

---
 rtl/proc_control_fsm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/proc_control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit processor: one state per cycle, Moore outputs from state and IR.
// Write strobes are masked by reset so no datapath state changes while reset is high.
module proc_control_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ir,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        ir_ld,
    output logic [7:0]  d_addr,
    output logic        d_wr,
    output logic        rf_s,
    output logic [3:0]  rf_w_addr,
    output logic        rf_w_wr,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    output logic [2:0]  alu_s,
    output logic [3:0]  state_o,
    output logic        halted
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOADA  = 4'd4,
        ST_LOADB  = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode;

    // Ungated write strobes; the reset mask is applied at the ports.
    logic       pc_up_raw;
    logic       ir_ld_raw;
    logic       d_wr_raw;
    logic       rf_w_wr_raw;

    assign opcode = ir[15:12];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_d = ST_NOOP;
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOADA;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_NOOP:   state_d = ST_FETCH;
            ST_LOADA:  state_d = ST_LOADB;
            ST_LOADB:  state_d = ST_FETCH;
            ST_STORE:  state_d = ST_FETCH;
            ST_ADD:    state_d = ST_FETCH;
            ST_SUB:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        pc_clr      = 1'b0;
        pc_up_raw   = 1'b0;
        ir_ld_raw   = 1'b0;
        d_addr      = 8'h00;
        d_wr_raw    = 1'b0;
        rf_s        = 1'b0;
        rf_w_addr   = 4'h0;
        rf_w_wr_raw = 1'b0;
        rf_ra_addr  = 4'h0;
        rf_rb_addr  = 4'h0;
        alu_s       = ALU_ZERO;
        halted      = 1'b0;
        case (state_q)
            ST_INIT: begin
                pc_clr = 1'b1;
            end
            ST_FETCH: begin
                ir_ld_raw = 1'b1;
                pc_up_raw = 1'b1;
            end
            // LoadA only presents the address; the synchronous RAM returns data in LoadB.
            ST_LOADA: begin
                d_addr = ir[11:4];
                rf_s   = 1'b1;
            end
            ST_LOADB: begin
                d_addr      = ir[11:4];
                rf_s        = 1'b1;
                rf_w_addr   = ir[3:0];
                rf_w_wr_raw = 1'b1;
            end
            ST_STORE: begin
                rf_ra_addr = ir[11:8];
                d_addr     = ir[7:0];
                d_wr_raw   = 1'b1;
            end
            ST_ADD: begin
                rf_ra_addr  = ir[11:8];
                rf_rb_addr  = ir[7:4];
                rf_w_addr   = ir[3:0];
                rf_w_wr_raw = 1'b1;
                alu_s       = ALU_ADD;
            end
            ST_SUB: begin
                rf_ra_addr  = ir[11:8];
                rf_rb_addr  = ir[7:4];
                rf_w_addr   = ir[3:0];
                rf_w_wr_raw = 1'b1;
                alu_s       = ALU_SUB;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc_up   = pc_up_raw   & ~reset;
    assign ir_ld   = ir_ld_raw   & ~reset;
    assign d_wr    = d_wr_raw    & ~reset;
    assign rf_w_wr = rf_w_wr_raw & ~reset;
    assign state_o = state_q;

endmodule
